// File: rtl/dmem_responder_pkg.sv
// Shared word/array defines and types for the data-memory responder.
// Optional clear-on-reset sweep is enabled by defining DMEM_CLEAR_ON_RESET_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef DMEM_DEPTH
`define DMEM_DEPTH 1024
`endif
`ifndef DMEM_AW
`define DMEM_AW 10
`endif
`ifndef DMEM_ST_CLEAR
`define DMEM_ST_CLEAR 1'b0
`endif
`ifndef DMEM_ST_READY
`define DMEM_ST_READY 1'b1
`endif

package dmem_responder_pkg;

  localparam int DMEM_W     = `WORD_WIDTH;
  localparam int DMEM_DEPTH = `DMEM_DEPTH;
  localparam int DMEM_AW    = `DMEM_AW;

  typedef enum logic {
    ST_CLEAR = `DMEM_ST_CLEAR,
    ST_READY = `DMEM_ST_READY
  } dmem_state_e;

endpackage

// File: rtl/dmem_wbuf.sv
// Single-entry store buffer: captures a store, commits it to the array on the
// following edge, and forwards its data to a matching load in between.
module dmem_wbuf #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          store_fire,
  input  logic [AW-1:0] store_idx,
  input  logic [W-1:0]  store_data,
  input  logic [AW-1:0] lookup_idx,
  output logic          commit_en,
  output logic [AW-1:0] commit_idx,
  output logic [W-1:0]  commit_data,
  output logic          fwd_hit,
  output logic [W-1:0]  fwd_data
);

  logic          wb_valid;
  logic [AW-1:0] wb_idx;
  logic [W-1:0]  wb_data;

  // A valid entry always drains on the next edge, whether or not a new store
  // replaces it, so the buffer never back-pressures the mem stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= store_fire;
      if (store_fire) begin
        wb_idx  <= store_idx;
        wb_data <= store_data;
      end
    end
  end

  assign commit_en   = wb_valid;
  assign commit_idx  = wb_idx;
  assign commit_data = wb_data;
  assign fwd_hit     = wb_valid && (wb_idx == lookup_idx);
  assign fwd_data    = wb_data;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array, load mux with store forwarding, range check
// and, with DMEM_CLEAR_ON_RESET_EN defined, a post-reset zeroing sweep.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int W     = DMEM_W,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  output logic         ready,
  output logic         addr_err,
  output dmem_state_e  dbg_state
);

  // Handshake: load_en and store_en are per-cycle valid qualifiers; ready is the
  // acceptance condition. There is no back-pressure: a store presented while
  // ready is low is dropped, and a load while ready is low returns zero.

  logic [W-1:0]  mem [DEPTH];

  logic [AW-1:0] l_idx;
  logic [AW-1:0] s_idx;
  logic          l_oor;
  logic          s_oor;
  logic          store_fire;

  logic          commit_en;
  logic [AW-1:0] commit_idx;
  logic [W-1:0]  commit_data;
  logic          fwd_hit;
  logic [W-1:0]  fwd_data;

  logic          clr_we;
  logic [AW-1:0] clr_idx;

  logic          unused_byte_bits;

  assign l_idx = l_addr[AW+1:2];
  assign s_idx = s_addr[AW+1:2];
  assign l_oor = |l_addr[W-1:AW+2];
  assign s_oor = |s_addr[W-1:AW+2];
  assign unused_byte_bits = ^{l_addr[1:0], s_addr[1:0]};

  assign store_fire = store_en && ready && !s_oor;

`ifdef DMEM_CLEAR_ON_RESET_EN
  dmem_state_e   state_q;
  dmem_state_e   state_d;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign clr_idx   = clr_cnt;
  assign ready     = (state_q == ST_READY);
  assign dbg_state = state_q;
`else
  assign clr_we    = 1'b0;
  assign clr_idx   = '0;
  assign ready     = 1'b1;
  assign dbg_state = ST_READY;
`endif

  dmem_wbuf #(
    .W  (W),
    .AW (AW)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .store_fire  (store_fire),
    .store_idx   (s_idx),
    .store_data  (s_data),
    .lookup_idx  (l_idx),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data)
  );

  // Sweep writes and buffer commits never coincide: the buffer is emptied by
  // reset and cannot refill until ready is high.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (commit_en) begin
      mem[commit_idx] <= commit_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if ((store_en && ready && s_oor) || (load_en && l_oor)) begin
      addr_err <= 1'b1;
    end
  end

  always_comb begin
    l_data = '0;
    if (load_en && ready && !l_oor) begin
      l_data = fwd_hit ? fwd_data : mem[l_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; covers both builds of DMEM_CLEAR_ON_RESET_EN.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [31:0] l_addr;
  logic [31:0] l_data;
  logic        store_en;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic        ready;
  logic        addr_err;
  dmem_state_e dbg_state;

  int vectors;
  int errors;

  dmem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .l_addr    (l_addr),
    .l_data    (l_data),
    .store_en  (store_en),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .ready     (ready),
    .addr_err  (addr_err),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    store_en = 1'b1;
    s_addr   = addr;
    s_data   = data;
    tick();
    store_en = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    load_en = 1'b1;
    l_addr  = addr;
    #1;
    check(tag, l_data, exp);
  endtask

  // Counts edges until ready rises; injects an in-range and an out-of-range
  // store early in the sweep, both of which must be ignored.
  task automatic sweep(output int cycles, output bit nonzero);
    cycles  = 0;
    nonzero = 1'b0;
    load_en = 1'b1;
    l_addr  = 32'h40;
    while (!ready && cycles < 2000) begin
      store_en = (cycles == 10) || (cycles == 11);
      s_addr   = (cycles == 10) ? 32'h40 : 32'h1000;
      s_data   = 32'h99;
      #1;
      if (l_data !== 32'h0) nonzero = 1'b1;
      tick();
      cycles++;
    end
    store_en = 1'b0;
  endtask

  int cyc;
  bit nz;

  initial begin
    vectors  = 0;
    errors   = 0;
    rst_n    = 1'b0;
    load_en  = 1'b1;
    l_addr   = 32'h40;
    store_en = 1'b0;
    s_addr   = '0;
    s_data   = '0;
    tick();
    tick();
    check("reset_addr_err", {31'b0, addr_err}, 32'h0);
`ifdef DMEM_CLEAR_ON_RESET_EN
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_ldata", l_data, 32'h0);
    rst_n = 1'b1;
    sweep(cyc, nz);
    check("sweep_cycles", 32'(cyc), 32'd1024);
    check("sweep_ldata_zero", {31'b0, nz}, 32'h0);
    check("sweep_ready", {31'b0, ready}, 32'h1);
    check("sweep_store_dropped", l_data, 32'h0);
    check("sweep_no_addr_err", {31'b0, addr_err}, 32'h0);
`else
    check("reset_ready", {31'b0, ready}, 32'h1);
    rst_n = 1'b1;
    #1;
    check("release_ready", {31'b0, ready}, 32'h1);
`endif

    // Store then forward, then read from the array
    store(32'h100, 32'hDEADBEEF);
    load_chk("fwd_0x100", 32'h100, 32'hDEADBEEF);
    tick();
    tick();
    tick();
    load_chk("array_0x100", 32'h100, 32'hDEADBEEF);
    load_chk("array_0x103", 32'h103, 32'hDEADBEEF);
    load_chk("no_load_en", 32'h100, 32'hDEADBEEF);
    load_en = 1'b0;
    #1;
    check("load_en_low", l_data, 32'h0);

    // Same-edge store and load: old data now, new data after the edge
    store_en = 1'b1;
    s_addr   = 32'h100;
    s_data   = 32'h11111111;
    load_chk("same_edge_old", 32'h100, 32'hDEADBEEF);
    tick();
    store_en = 1'b0;
    load_chk("same_edge_new", 32'h100, 32'h11111111);

    // Back-to-back stores, last store to a word wins
    store(32'h4, 32'h1);
    load_chk("b2b_fwd_first", 32'h4, 32'h1);
    store(32'h4, 32'h2);
    store(32'h8, 32'hA);
    store(32'hC, 32'hB);
    load_chk("b2b_0x4", 32'h4, 32'h2);
    load_chk("b2b_0x8", 32'h8, 32'hA);
    load_chk("b2b_0xC_fwd", 32'hC, 32'hB);
    tick();
    tick();
    load_chk("b2b_0xC_array", 32'hC, 32'hB);
    load_chk("b2b_0x100_kept", 32'h100, 32'h11111111);

    // Out-of-range store is dropped (would alias word 0) and flags addr_err
    store(32'h0, 32'h77);
    check("pre_oor_addr_err", {31'b0, addr_err}, 32'h0);
    load_en = 1'b0;
    store(32'h1000, 32'h55);
    check("oor_store_addr_err", {31'b0, addr_err}, 32'h1);
    load_chk("oor_load_zero", 32'h1000, 32'h0);
    tick();
    tick();
    load_chk("oor_no_alias", 32'h0, 32'h77);
    check("addr_err_sticky", {31'b0, addr_err}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("addr_err_cleared", {31'b0, addr_err}, 32'h0);
    tick();
    rst_n = 1'b1;
    load_en = 1'b1;
    load_chk("oor_load_only", 32'h8000_0000, 32'h0);
    tick();
    check("oor_load_addr_err", {31'b0, addr_err}, 32'h1);

`ifdef DMEM_CLEAR_ON_RESET_EN
    // Reset mid-sweep at clr_cnt=500 restarts the full sweep
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    check("mid_sweep_not_ready", {31'b0, ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_sweep_state", {31'b0, dbg_state}, {31'b0, ST_CLEAR});
    tick();
    rst_n = 1'b1;
    sweep(cyc, nz);
    check("resweep_cycles", 32'(cyc), 32'd1024);
    check("resweep_store_dropped", l_data, 32'h0);
    load_chk("resweep_0x100", 32'h100, 32'h0);
    load_chk("resweep_0x4", 32'h4, 32'h0);
    check("resweep_addr_err", {31'b0, addr_err}, 32'h0);
    // Reset while ready drops ready without a clock edge
    rst_n = 1'b0;
    #1;
    check("async_ready_drop", {31'b0, ready}, 32'h0);
    tick();
    rst_n = 1'b1;
`else
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("nomacro_ready", {31'b0, ready}, 32'h1);
    store(32'h20, 32'h1234);
    tick();
    load_chk("nomacro_0x20", 32'h20, 32'h1234);
    // Reset while an entry is buffered discards it
    store(32'h24, 32'hAAAA);
    tick();
    store(32'h24, 32'hBBBB);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    load_chk("reset_discards_wbuf", 32'h24, 32'hAAAA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
